// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the processor datapath.
// Moore machine; every output is a decode of the registered state, and the address
// fields are taken from the instruction register contents.
// Optional build macro: CU_SINGLE_STEP_EN adds a `step` input and an IDLE state
// that waits for step=1 before each fetch.
//
// state  | code | meaning
// INIT   |  0   | PC cleared, all enables low
// FETCH  |  1   | load IR from ROM, advance PC
// DECODE |  2   | choose execute state from opcode
// LOAD_A |  3   | present data-memory address (RAM read latency)
// LOAD_B |  4   | write memory data into register file
// STORE  |  5   | write register A into data memory
// ADD    |  6   | RF[w] = RF[a] + RF[b]
// SUB    |  7   | RF[w] = RF[a] - RF[b]
// NOOP   |  8   | no operation (also illegal opcodes)
// HALT   |  9   | parked until reset
// IDLE   | 10   | single-step wait (only with CU_SINGLE_STEP_EN)

module control_unit #(
    parameter int OP_W    = 4,
    parameter int DADDR_W = 8,
    parameter int RADDR_W = 4,
    parameter int IR_W    = 16
) (
    input  logic               clk,
    input  logic               clear_n,
`ifdef CU_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic [IR_W-1:0]    ir,
    output logic               pc_clr,
    output logic               pc_up,
    output logic               ir_ld,
    output logic [DADDR_W-1:0] d_addr,
    output logic               d_wr,
    output logic               rf_s,
    output logic [RADDR_W-1:0] rf_w_addr,
    output logic               rf_w_en,
    output logic [RADDR_W-1:0] rf_ra_addr,
    output logic [RADDR_W-1:0] rf_rb_addr,
    output logic [2:0]         alu_s,
    output logic [3:0]         state_out
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD_A = 4'd3,
        S_LOAD_B = 4'd4,
        S_STORE  = 4'd5,
        S_ADD    = 4'd6,
        S_SUB    = 4'd7,
        S_NOOP   = 4'd8,
        S_HALT   = 4'd9,
        S_IDLE   = 4'd10
    } state_t;

    localparam logic [OP_W-1:0] OP_NOOP  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(5);

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    // Instruction fields: opcode in the top bits, then two layouts below it.
    logic [OP_W-1:0]    op;
    logic [DADDR_W-1:0] f_load_addr;
    logic [DADDR_W-1:0] f_store_addr;
    logic [RADDR_W-1:0] f_ra;
    logic [RADDR_W-1:0] f_rb;
    logic [RADDR_W-1:0] f_rw;

    assign op           = ir[IR_W-1 -: OP_W];
    assign f_load_addr  = ir[IR_W-OP_W-1 -: DADDR_W];
    assign f_store_addr = ir[DADDR_W-1:0];
    assign f_ra         = ir[IR_W-OP_W-1 -: RADDR_W];
    assign f_rb         = ir[IR_W-OP_W-RADDR_W-1 -: RADDR_W];
    assign f_rw         = ir[RADDR_W-1:0];

    state_t state;
    state_t state_nxt;
    state_t after_exec;

    // State register; clear_n is sampled on the clock and overrides every state.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ir only steers the machine in DECODE.
    always_comb begin
        state_nxt  = state;
`ifdef CU_SINGLE_STEP_EN
        after_exec = S_IDLE;
`else
        after_exec = S_FETCH;
`endif
        unique case (state)
            S_INIT:   state_nxt = after_exec;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    OP_NOOP:  state_nxt = S_NOOP;
                    OP_STORE: state_nxt = S_STORE;
                    OP_LOAD:  state_nxt = S_LOAD_A;
                    OP_ADD:   state_nxt = S_ADD;
                    OP_SUB:   state_nxt = S_SUB;
                    OP_HALT:  state_nxt = S_HALT;
                    default:  state_nxt = S_NOOP;
                endcase
            end
            S_LOAD_A: state_nxt = S_LOAD_B;
            S_LOAD_B: state_nxt = after_exec;
            S_STORE:  state_nxt = after_exec;
            S_ADD:    state_nxt = after_exec;
            S_SUB:    state_nxt = after_exec;
            S_NOOP:   state_nxt = after_exec;
            S_HALT:   state_nxt = S_HALT;
`ifdef CU_SINGLE_STEP_EN
            S_IDLE:   state_nxt = step ? S_FETCH : S_IDLE;
`else
            S_IDLE:   state_nxt = S_FETCH;
`endif
            default:  state_nxt = S_INIT;
        endcase
    end

    // Output decode of the current state; unused fields stay at zero.
    always_comb begin
        pc_clr     = 1'b0;
        pc_up      = 1'b0;
        ir_ld      = 1'b0;
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_addr  = '0;
        rf_w_en    = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_s      = ALU_PASS;
        unique case (state)
            S_INIT: pc_clr = 1'b1;
            S_FETCH: begin
                ir_ld = 1'b1;
                pc_up = 1'b1;
            end
            S_LOAD_A, S_LOAD_B: begin
                d_addr    = f_load_addr;
                rf_s      = 1'b1;
                rf_w_addr = f_rw;
                rf_w_en   = (state == S_LOAD_B);
            end
            S_STORE: begin
                rf_ra_addr = f_ra;
                d_addr     = f_store_addr;
                d_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                rf_ra_addr = f_ra;
                rf_rb_addr = f_rb;
                rf_w_addr  = f_rw;
                rf_w_en    = 1'b1;
                alu_s      = (state == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: ;
        endcase
    end

    assign state_out = state;

endmodule
